// File: rtl/alu_issue.sv
//==============================================================================
// Module   : alu_issue
// Purpose  : Initiator-side sequencer for the bit-serial ALU start/done
//            command interface. Accepts one decoded OP / OP-IMM transaction,
//            derives the ALU op and operand B, issues a single start pulse,
//            waits for done and returns the tagged result over valid/ready.
// Options  : ALU_ISSUE_TIMEOUT_EN - enables the WAIT-state watchdog
//            (TIMEOUT_CYCLES) and the out_timeout flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_issue #(
    parameter int TIMEOUT_CYCLES = 96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [31:0] alu_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd_idx,
    output logic [31:0] out_result,
    output logic        out_illegal,
    output logic        out_timeout
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The watchdog counter is 8 bits wide and must outlast the 64-cycle ALU.
    if ((TIMEOUT_CYCLES <= 64) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range_check
        $error("alu_issue: TIMEOUT_CYCLES must be in the range 65..255");
    end

    state_t      state_q,       state_d;
    logic        alu_start_q,   alu_start_d;
    logic [3:0]  alu_op_q,      alu_op_d;
    logic [31:0] alu_rs1_q,     alu_rs1_d;
    logic [31:0] alu_rs2_q,     alu_rs2_d;
    logic        out_valid_q,   out_valid_d;
    logic [4:0]  out_rd_idx_q,  out_rd_idx_d;
    logic [31:0] out_result_q,  out_result_d;
    logic        out_illegal_q, out_illegal_d;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  wait_cnt_q,    wait_cnt_d;
    logic        out_timeout_q, out_timeout_d;
`endif

    // Decode results for the instruction currently offered on the input.
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [31:0] dec_rs2;

    wire [6:0] w_opcode = instr[6:0];
    wire [2:0] w_func3  = instr[14:12];
    wire [6:0] w_func7  = instr[31:25];

    // The rs1 field is resolved upstream; only its value arrives here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[19:15];

    // Map OP / OP-IMM encodings to {sub/arith, func3} and select operand B.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 4'd0;
        dec_rs2   = rs2_val;
        case (w_opcode)
            OPC_OP: begin
                dec_rs2 = rs2_val;
                if (w_func7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_op    = {1'b0, w_func3};
                end else if ((w_func7 == F7_ALT) &&
                             ((w_func3 == 3'b000) || (w_func3 == 3'b101))) begin
                    dec_legal = 1'b1;
                    dec_op    = {1'b1, w_func3};
                end
            end
            OPC_OP_IMM: begin
                case (w_func3)
                    3'b001: begin
                        dec_rs2 = {27'd0, instr[24:20]};
                        if (w_func7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b0001;
                        end
                    end
                    3'b101: begin
                        dec_rs2 = {27'd0, instr[24:20]};
                        if (w_func7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b0101;
                        end else if (w_func7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b1101;
                        end
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op    = {1'b0, w_func3};
                        dec_rs2   = {{20{instr[31]}}, instr[31:20]};
                    end
                endcase
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d       = state_q;
        alu_start_d   = 1'b0;
        alu_op_d      = alu_op_q;
        alu_rs1_d     = alu_rs1_q;
        alu_rs2_d     = alu_rs2_q;
        out_valid_d   = out_valid_q;
        out_rd_idx_d  = out_rd_idx_q;
        out_result_d  = out_result_q;
        out_illegal_d = out_illegal_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        out_timeout_d = out_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    out_rd_idx_d  = instr[11:7];
                    out_result_d  = 32'd0;
                    out_illegal_d = ~dec_legal;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    out_timeout_d = 1'b0;
`endif
                    if (dec_legal) begin
                        alu_op_d    = dec_op;
                        alu_rs1_d   = rs1_val;
                        alu_rs2_d   = dec_rs2;
                        alu_start_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end else begin
                        // Illegal instructions skip the ALU entirely.
                        out_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
`ifdef ALU_ISSUE_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving together with the watchdog limit takes priority.
                if (alu_done) begin
                    out_result_d = alu_rd;
                    out_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LIMIT) begin
                    out_result_d  = 32'd0;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_start_q   <= 1'b0;
            alu_op_q      <= 4'd0;
            alu_rs1_q     <= 32'd0;
            alu_rs2_q     <= 32'd0;
            out_valid_q   <= 1'b0;
            out_rd_idx_q  <= 5'd0;
            out_result_q  <= 32'd0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_start_q   <= alu_start_d;
            alu_op_q      <= alu_op_d;
            alu_rs1_q     <= alu_rs1_d;
            alu_rs2_q     <= alu_rs2_d;
            out_valid_q   <= out_valid_d;
            out_rd_idx_q  <= out_rd_idx_d;
            out_result_q  <= out_result_d;
            out_illegal_q <= out_illegal_d;
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    // Watchdog counter and timeout flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= 8'd0;
            out_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            out_timeout_q <= out_timeout_d;
        end
    end

    assign out_timeout = out_timeout_q;
`else
    assign out_timeout = 1'b0;
`endif

    assign in_ready    = (state_q == ST_IDLE);
    assign alu_start   = alu_start_q;
    assign alu_op      = alu_op_q;
    assign alu_rs1     = alu_rs1_q;
    assign alu_rs2     = alu_rs2_q;
    assign out_valid   = out_valid_q;
    assign out_rd_idx  = out_rd_idx_q;
    assign out_result  = out_result_q;
    assign out_illegal = out_illegal_q;

endmodule

`default_nettype wire
